// File: rtl/skeleton_draw_scheduler_if.sv
// Segment handshake between the skeleton draw scheduler and the line-draw engine.
// The scheduler owns valid and the segment payload; the line engine owns ready.
interface skeleton_draw_scheduler_if;
    logic        seg_valid;
    logic        seg_ready;
    logic [9:0]  seg_x0;
    logic [9:0]  seg_y0;
    logic [9:0]  seg_x1;
    logic [9:0]  seg_y1;
    logic [11:0] seg_color;

    modport master (
        output seg_valid, seg_x0, seg_y0, seg_x1, seg_y1, seg_color,
        input  seg_ready
    );

    modport slave (
        input  seg_valid, seg_x0, seg_y0, seg_x1, seg_y1, seg_color,
        output seg_ready
    );
endinterface

// File: rtl/skeleton_draw_scheduler.sv
// Brings SPI pose frames into the clk domain and, during vertical blanking, erases
// the previous three-segment skeleton and draws the new one through the line engine.
module skeleton_draw_scheduler #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_done,
    input  logic [127:0]                      frame_data,
    input  logic                              vblank,
    skeleton_draw_scheduler_if.master         seg,
    output logic                              busy,
    output logic                              frame_drawn,
    output logic [7:0]                        drop_cnt
);

    typedef enum logic [2:0] {
        IDLE, ERASE0, ERASE1, ERASE2, DRAW0, DRAW1, DRAW2
    } state_t;

    // Point storage: index 2*i is x_{i+1}, index 2*i+1 is y_{i+1}.
    typedef logic [7:0][9:0] pts_t;

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);

    function automatic pts_t unpack_clamp(input logic [127:0] d);
        pts_t       p;
        logic [9:0] f;
        for (int i = 0; i < 8; i++) begin
            f = d[127 - 10*i -: 10];
            if (i % 2 == 0) p[i] = (f > X_MAX) ? X_MAX : f;
            else            p[i] = (f > Y_MAX) ? Y_MAX : f;
        end
        return p;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   capture;
    logic                   launch;
    logic                   xfer;
    logic                   pending;
    logic                   have_prev;
    pts_t                   pend_pts;
    pts_t                   new_pts;
    pts_t                   cur_pts;
    logic [11:0]            pend_rgb;
    logic [11:0]            new_rgb;
    state_t                 state;
    state_t                 state_n;
    pts_t                   src_pts;
    logic [11:0]            nxt_color;
    logic [1:0]             nxt_idx;
    logic                   seg_load;
    logic [9:0]             x0_q, y0_q, x1_q, y1_q;
    logic [11:0]            color_q;
    logic                   unused_bits;

    assign unused_bits = ^frame_data[35:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], frame_done};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign capture = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign launch  = (state == IDLE) & pending & vblank;
    assign xfer    = seg.seg_valid & seg.seg_ready;

    // A capture in the same cycle as a launch refills pending without counting a drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 1'b0;
            pend_pts <= '0;
            pend_rgb <= '0;
            drop_cnt <= '0;
        end else if (capture) begin
            pend_pts <= unpack_clamp(frame_data);
            pend_rgb <= frame_data[47:36];
            pending  <= 1'b1;
            if (pending && !launch && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end else if (launch) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_pts     <= '0;
            new_rgb     <= '0;
            cur_pts     <= '0;
            have_prev   <= 1'b0;
            frame_drawn <= 1'b0;
        end else begin
            frame_drawn <= 1'b0;
            if (launch) begin
                new_pts <= pend_pts;
                new_rgb <= pend_rgb;
            end
            if (state == DRAW2 && xfer) begin
                cur_pts     <= new_pts;
                have_prev   <= 1'b1;
                frame_drawn <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (launch) state_n = have_prev ? ERASE0 : DRAW0;
            ERASE0:  if (xfer)   state_n = ERASE1;
            ERASE1:  if (xfer)   state_n = ERASE2;
            ERASE2:  if (xfer)   state_n = DRAW0;
            DRAW0:   if (xfer)   state_n = DRAW1;
            DRAW1:   if (xfer)   state_n = DRAW2;
            DRAW2:   if (xfer)   state_n = IDLE;
            default:             state_n = IDLE;
        endcase
    end

    // The launch edge also loads the new register, so DRAW0 straight from IDLE reads pending.
    always_comb begin
        src_pts   = (state == IDLE) ? pend_pts : new_pts;
        nxt_color = (state == IDLE) ? pend_rgb : new_rgb;
        nxt_idx   = 2'd0;
        unique case (state_n)
            ERASE0:  begin src_pts = cur_pts; nxt_color = BG_COLOR; nxt_idx = 2'd0; end
            ERASE1:  begin src_pts = cur_pts; nxt_color = BG_COLOR; nxt_idx = 2'd1; end
            ERASE2:  begin src_pts = cur_pts; nxt_color = BG_COLOR; nxt_idx = 2'd2; end
            DRAW1:   nxt_idx = 2'd1;
            DRAW2:   nxt_idx = 2'd2;
            default: nxt_idx = 2'd0;
        endcase
    end

    assign seg_load = (state_n != state) && (state_n != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (seg_load) begin
            x0_q    <= src_pts[{nxt_idx, 1'b0}];
            y0_q    <= src_pts[{nxt_idx, 1'b0} + 3'd1];
            x1_q    <= src_pts[{nxt_idx, 1'b0} + 3'd2];
            y1_q    <= src_pts[{nxt_idx, 1'b0} + 3'd3];
            color_q <= nxt_color;
        end
    end

    assign seg.seg_valid = (state != IDLE);
    assign seg.seg_x0    = x0_q;
    assign seg.seg_y0    = y0_q;
    assign seg.seg_x1    = x1_q;
    assign seg.seg_y1    = y1_q;
    assign seg.seg_color = color_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_skeleton_draw_scheduler.sv
// Self-checking bench for skeleton_draw_scheduler: directed scenarios plus random
// frames, compared against a segment-list model of the redraw sequence.
module tb_skeleton_draw_scheduler;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef struct {
        int          x[4];
        int          y[4];
        logic [11:0] rgb;
    } frame_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         frame_done = 1'b0;
    logic [127:0] frame_data = '0;
    logic         vblank = 1'b0;
    logic         busy;
    logic         frame_drawn;
    logic [7:0]   drop_cnt;

    skeleton_draw_scheduler_if bus ();

    skeleton_draw_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .frame_done  (frame_done),
        .frame_data  (frame_data),
        .vblank      (vblank),
        .seg         (bus),
        .busy        (busy),
        .frame_drawn (frame_drawn),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [51:0] exp_q[$];
    logic [51:0] obs_q[$];
    int          drawn_cnt = 0;
    int          drawn_base = 0;
    int          valid_cycles = 0;
    logic        prev_valid = 1'b0;
    logic        prev_xfer = 1'b0;
    int          rmode = 0;
    int          cyc = 0;
    frame_t      m_prev;
    bit          m_have_prev = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] clampx(input int v);
        return 10'((v > H_ACTIVE - 1) ? H_ACTIVE - 1 : v);
    endfunction

    function automatic logic [9:0] clampy(input int v);
        return 10'((v > V_ACTIVE - 1) ? V_ACTIVE - 1 : v);
    endfunction

    function automatic logic [51:0] seg_word(input int ax, input int ay, input int bx, input int by,
                                             input logic [11:0] c);
        return {clampx(ax), clampy(ay), clampx(bx), clampy(by), c};
    endfunction

    function automatic frame_t make_frame(input int x1, input int y1, input int x2, input int y2,
                                          input int x3, input int y3, input int x4, input int y4,
                                          input logic [11:0] rgb);
        frame_t f;
        f.x[0] = x1; f.y[0] = y1; f.x[1] = x2; f.y[1] = y2;
        f.x[2] = x3; f.y[2] = y3; f.x[3] = x4; f.y[3] = y4;
        f.rgb  = rgb;
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < 4; i++) begin
            f.x[i] = int'($urandom_range(0, 1023));
            f.y[i] = int'($urandom_range(0, 1023));
        end
        f.rgb = 12'($urandom);
        return f;
    endfunction

    // Unused low bits are filled with noise so the design must ignore them.
    function automatic logic [127:0] pack_frame(input frame_t f);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            d[127 - 20*i -: 10] = 10'(f.x[i]);
            d[117 - 20*i -: 10] = 10'(f.y[i]);
        end
        d[47:36] = f.rgb;
        return d;
    endfunction

    // Redraw model: erase the last drawn skeleton in black (if any), then draw the new one.
    task automatic model_redraw(input frame_t f);
        if (m_have_prev)
            for (int k = 0; k < 3; k++)
                exp_q.push_back(seg_word(m_prev.x[k], m_prev.y[k], m_prev.x[k+1], m_prev.y[k+1], 12'h000));
        for (int k = 0; k < 3; k++)
            exp_q.push_back(seg_word(f.x[k], f.y[k], f.x[k+1], f.y[k+1], f.rgb));
        m_prev      = f;
        m_have_prev = 1'b1;
    endtask

    // Monitor: every presented segment must be the next one the model expects, and
    // every accepted one is logged; frame_drawn cycles are counted.
    always @(negedge clk) begin
        logic [51:0] cur;
        int          idx;
        cur = {bus.seg_x0, bus.seg_y0, bus.seg_x1, bus.seg_y1, bus.seg_color};
        if (reset) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (bus.seg_valid) begin
                valid_cycles++;
                idx = obs_q.size();
                if (idx < exp_q.size()) checkOutput("seg_present", cur, exp_q[idx]);
                else                    checkOutput("unexpected_valid", bus.seg_valid, 1'b0);
                if (bus.seg_ready) obs_q.push_back(cur);
            end
            if (frame_drawn) drawn_cnt++;
            prev_valid = bus.seg_valid;
            prev_xfer  = bus.seg_valid & bus.seg_ready;
        end
    end

    // Line-engine model: mode 0 always ready, mode 1 stalls two cycles per segment, else random.
    always @(posedge clk) begin
        #1;
        if (!prev_valid || prev_xfer) cyc = 0;
        else                          cyc++;
        case (rmode)
            0:       bus.seg_ready = 1'b1;
            1:       bus.seg_ready = (cyc == 2);
            default: bus.seg_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic applyStimulus(input logic [127:0] d);
        @(posedge clk); #1;
        frame_data = d;
        frame_done = 1'b1;
        repeat (4) @(posedge clk);
        #1 frame_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        exp_q.delete();
        obs_q.delete();
        valid_cycles = 0;
        drawn_base   = drawn_cnt;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (drawn_cnt == drawn_base && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_timeout"}, (n < 500), 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_redraw(input string tag, input int exp_cycles);
        checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            checkOutput({tag, "_seg"}, obs_q[i], exp_q[i]);
        checkOutput({tag, "_drawn_pulses"}, drawn_cnt - drawn_base, 1);
        checkOutput({tag, "_busy_after"}, busy, 1'b0);
        checkOutput({tag, "_valid_after"}, bus.seg_valid, 1'b0);
        if (exp_cycles >= 0) checkOutput({tag, "_cycles"}, valid_cycles, exp_cycles);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_have_prev = 1'b0;
    endtask

    initial begin
        frame_t f;
        int     n;
        bus.seg_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", bus.seg_valid, 1'b0);
        checkOutput("rst_x0", bus.seg_x0, 10'd0);
        checkOutput("rst_y1", bus.seg_y1, 10'd0);
        checkOutput("rst_color", bus.seg_color, 12'h000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_drawn", frame_drawn, 1'b0);
        checkOutput("rst_drop", drop_cnt, 8'd0);
        @(posedge clk); #1 reset = 1'b0;

        // First frame: draws only, back to back
        vblank = 1'b1;
        rmode  = 0;
        begin_frame();
        f = make_frame(10, 20, 30, 40, 50, 60, 70, 80, 12'hF00);
        model_redraw(f);
        applyStimulus(pack_frame(f));
        wait_done("first");
        check_redraw("first", 3);

        // Second frame: erase old skeleton then draw new
        begin_frame();
        f = make_frame(100, 20, 30, 40, 50, 60, 70, 80, 12'h0F0);
        model_redraw(f);
        applyStimulus(pack_frame(f));
        wait_done("second");
        check_redraw("second", 6);

        // Random frames under random back-pressure
        rmode = 2;
        for (int r = 0; r < 6; r++) begin
            begin_frame();
            f = rand_frame();
            model_redraw(f);
            applyStimulus(pack_frame(f));
            wait_done("random");
            check_redraw("random", -1);
        end

        // Clamping with 0,0,1 back-pressure after reset
        do_reset();
        rmode = 1;
        begin_frame();
        f = make_frame(1023, 600, 30, 40, 50, 60, 70, 80, 12'h00F);
        model_redraw(f);
        applyStimulus(pack_frame(f));
        wait_done("clamp");
        check_redraw("clamp", 9);
        if (obs_q.size() > 0) begin
            checkOutput("clamp_x0", obs_q[0][51:42], 10'd639);
            checkOutput("clamp_y0", obs_q[0][41:32], 10'd479);
        end

        // Overrun while vblank is low: only the last frame is drawn
        do_reset();
        rmode  = 0;
        vblank = 1'b0;
        begin_frame();
        for (int i = 0; i < 3; i++) begin
            f = rand_frame();
            applyStimulus(pack_frame(f));
        end
        checkOutput("overrun_drop", drop_cnt, 8'd2);
        checkOutput("overrun_gated", bus.seg_valid, 1'b0);
        model_redraw(f);
        vblank = 1'b1;
        wait_done("overrun");
        check_redraw("overrun", 3);

        // Reset during DRAW1 drops the segment and forgets the previous skeleton
        rmode = 1;
        begin_frame();
        f = rand_frame();
        model_redraw(f);
        applyStimulus(pack_frame(f));
        n = 0;
        while (obs_q.size() < 4 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("middraw_reach", (n < 300), 1'b1);
        @(posedge clk); #1;
        checkOutput("middraw_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("middraw_valid_drop", bus.seg_valid, 1'b0);
        checkOutput("middraw_busy_drop", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_have_prev = 1'b0;
        rmode = 0;
        begin_frame();
        f = rand_frame();
        model_redraw(f);
        applyStimulus(pack_frame(f));
        wait_done("after_reset");
        check_redraw("after_reset", 3);

        // drop_cnt saturation
        vblank = 1'b0;
        for (int i = 0; i < 258; i++) applyStimulus(pack_frame(rand_frame()));
        checkOutput("drop_saturate", drop_cnt, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skeleton_draw_scheduler.md
Name: skeleton_draw_scheduler

Overview:
Sits between the SPI frame receiver and the line-draw engine of the VGA overlay. It takes each completed 128-bit pose frame and brings it into the clk domain. During vertical blanking it sequences the skeleton redraw: it first erases the three previously drawn segments in background colour, then draws the three new segments (P1-P2, P2-P3, P3-P4) in the frame colour. Each segment is handed to the line engine over a valid/ready handshake.

Parameters:
H_ACTIVE, 640, visible width; x coordinates clamp to H_ACTIVE-1
V_ACTIVE, 480, visible height; y coordinates clamp to V_ACTIVE-1
BG_COLOR, 12'h000, {r,g,b} colour used for erase segments
SYNC_STAGES, 2, synchroniser depth for frame_done (minimum 2)

Ports:
clk  in  1  system clock; only clock of the block
reset  in  1  asynchronous, active-high reset
frame_done  in  1  SPI frame-complete level, from the sck domain
frame_data  in  128  captured SPI frame; stable while frame_done is high
vblank  in  1  high during VGA vertical blanking (clk domain)
seg_valid  out  1  segment presented to the line engine
seg_ready  in  1  line engine accepts the segment
seg_x0, seg_y0, seg_x1, seg_y1  out  10 each  segment endpoints
seg_color  out  12  {r,g,b} for the segment
busy  out  1  high in any ERASE/DRAW state
frame_drawn  out  1  one-cycle pulse when a redraw completes
drop_cnt  out  8  saturating count of overwritten pending frames

Behaviour:
- Reset (async, active-high): state=IDLE, seg_valid=0, all seg_* = 0, busy=0, frame_drawn=0, drop_cnt=0, pending=0, have_prev=0, synchroniser flops=0.
- Sync: frame_done passes through SYNC_STAGES flops, then a rising-edge detector. frame_data is sampled into the pending register on the cycle the edge is detected, and pending is set to 1.
- Pending is set while pending=1: the new data overwrites the old. drop_cnt increments and saturates at 255.
- Frame field mapping:
  - x1=[127:118], y1=[117:108], x2=[107:98], y2=[97:88]
  - x3=[87:78], y3=[77:68], x4=[67:58], y4=[57:48]
  - r=[47:44], g=[43:40], b=[39:36]; [35:0] are ignored
- Clamping at capture: x>=H_ACTIVE becomes H_ACTIVE-1; y>=V_ACTIVE becomes V_ACTIVE-1.
- States: IDLE, ERASE0..2, DRAW0..2.
- IDLE:
  - When pending=1 and vblank=1 at edge N, copy pending into the new register and clear pending.
  - Go to ERASE0 if have_prev=1, else DRAW0.
  - seg_valid and the segment data are registered and first appear at edge N+1.
- If a capture and an IDLE launch occur in the same cycle:
  - The launch takes the old pending contents.
  - The freshly captured frame becomes pending (pending stays 1).
  - drop_cnt does not increment.
- ERASEk: segment k of the current (last drawn) register, seg_color=BG_COLOR.
- DRAWk: segment k of the new register, seg_color={r,g,b} from the new register.
- Segment k endpoints are P(k+1) and P(k+2), i.e. (x_{k+1},y_{k+1}) to (x_{k+2},y_{k+2}).
- Handshake:
  - seg_valid, once high, holds with stable data until the transfer edge (seg_valid & seg_ready).
  - On transfer, the next state's segment is presented on the following cycle with seg_valid still high (no bubble).
  - ERASE2 advances to DRAW0.
  - After the transfer of DRAW2: seg_valid=0, current<=new, have_prev=1, frame_drawn=1 for one cycle, busy=0, state=IDLE.
- vblank falling during a sequence does not abort it; the sequence runs to completion.
- New frames arriving while busy only update pending; the active sequence is unaffected.
- seg_ready while seg_valid=0 is ignored.
- Reset mid-sequence drops the in-flight segment immediately and forgets have_prev, so the next frame draws without erase.

Test Plan:
- First frame: reset, then frame_done rising with x1=10,y1=20,x2=30,y2=40,x3=50,y3=60,x4=70,y4=80,rgb=F00, with vblank=1 and seg_ready=1 → exactly 3 segments: (10,20)-(30,40), (30,40)-(50,60), (50,60)-(70,80), all colour F00, back to back. No erase segments; frame_drawn pulses once.
- Second frame: x1=100, rgb=0F0 → 6 transfers. First three are the old segments with colour 000; last three are the new segments with colour 0F0.
- Back-pressure: seg_ready toggles 0,0,1 per segment → seg_valid and data hold steady across the stall cycles; total 9 cycles for 3 segments.
- Clamping: x1=1023, y1=600 → seg_x0=639, seg_y0=479.
- Overrun and gating: 3 frames arrive while vblank=0 → drop_cnt=2; when vblank rises, only the third frame is drawn.
- Mid-draw reset: assert reset during DRAW1 → seg_valid=0 that cycle. The next frame then produces only 3 draw transfers, with no erase.
